// File: rtl/des_sbox_sched.sv
// DES substitution sequencer: feeds the eight 6-bit S-box lookups of a 48-bit block
// through one shared table port and gathers the 32-bit result.
module des_sbox_sched #(
    parameter int LKUP_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] din,
    output logic        sbox_en,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_addr,
    input  logic [3:0]  sbox_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout
);

    // state | meaning
    // IDLE  | waiting for a block, in_ready high
    // ISSUE | one lookup per clock, k = 0..7
    // DRAIN | last registered lookup returning
    // DONE  | result presented until out_ready
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [47:0] din_q;
    logic [2:0]  sel_q;
    logic [5:0]  addr_q;
    logic [31:0] dout_q;
    logic        cap_vld_q;
    logic [2:0]  cap_sel_q;
    logic        accept;
    logic        cap_en;
    logic [2:0]  cap_sel;
    logic [5:0]  issue_addr;

    // DES bit 1 is the vector MSB, so S-box k+1 reads the k-th 6-bit field from the top.
    assign issue_addr = din_q[47 - 6*int'(k_q) -: 6];
    assign accept     = in_valid & in_ready & ~clr;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        in_ready  = 1'b0;
        sbox_en   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ISSUE;
                    k_d     = 3'd0;
                end
            end
            ISSUE: begin
                sbox_en = 1'b1;
                k_d     = k_q + 3'd1;
                if (k_q == 3'd7) state_d = (LKUP_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            k_d     = 3'd0;
        end
    end

    // Outside ISSUE the lookup port keeps showing the last issued select/address.
    assign sbox_sel  = sbox_en ? k_q        : sel_q;
    assign sbox_addr = sbox_en ? issue_addr : addr_q;
    assign dout      = dout_q;

    // Capture follows the delayed select, never the live counter.
    assign cap_en  = (LKUP_LAT == 0) ? sbox_en : cap_vld_q;
    assign cap_sel = (LKUP_LAT == 0) ? k_q     : cap_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= 3'd0;
            din_q     <= '0;
            sel_q     <= 3'd0;
            addr_q    <= 6'd0;
            dout_q    <= '0;
            cap_vld_q <= 1'b0;
            cap_sel_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cap_vld_q <= sbox_en & ~clr;
            cap_sel_q <= k_q;
            if (accept) din_q <= din;
            if (sbox_en) begin
                sel_q  <= k_q;
                addr_q <= issue_addr;
            end
            if (clr || accept) begin
                dout_q <= '0;
            end else if (cap_en) begin
                dout_q[31 - 4*int'(cap_sel) -: 4] <= sbox_dout;
            end
        end
    end

endmodule

// File: tb/tb_des_sbox_sched.sv
// Directed bench for des_sbox_sched: registered-ROM instance plus a combinational-table instance.
module tb_des_sbox_sched;

    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    logic        clk;
    logic        rst_n;
    logic        clr, in_valid, in_ready, sbox_en, out_valid, out_ready;
    logic [47:0] din;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_addr;
    logic [3:0]  sbox_dout;
    logic [31:0] dout;
    logic        l0_clr, l0_in_valid, l0_in_ready, l0_sbox_en, l0_out_valid, l0_out_ready;
    logic [47:0] l0_din;
    logic [2:0]  l0_sbox_sel;
    logic [5:0]  l0_sbox_addr;
    logic [3:0]  l0_sbox_dout;
    logic [31:0] l0_dout;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    des_sbox_sched #(.LKUP_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .sbox_en(sbox_en), .sbox_sel(sbox_sel), .sbox_addr(sbox_addr),
        .sbox_dout(sbox_dout), .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    des_sbox_sched #(.LKUP_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(l0_clr), .in_valid(l0_in_valid), .in_ready(l0_in_ready),
        .din(l0_din), .sbox_en(l0_sbox_en), .sbox_sel(l0_sbox_sel), .sbox_addr(l0_sbox_addr),
        .sbox_dout(l0_sbox_dout), .out_valid(l0_out_valid), .out_ready(l0_out_ready), .dout(l0_dout)
    );

    function automatic logic [3:0] sbox_lu(input logic [2:0] sel, input logic [5:0] a);
        int idx;
        idx = int'({a[5], a[0]}) * 16 + int'(a[4:1]);
        return SB[sel][255 - 4*idx -: 4];
    endfunction

    function automatic logic [31:0] ref_f(input logic [47:0] d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[31 - 4*k -: 4] = sbox_lu(3'(k), d[47 - 6*k -: 6]);
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) begin
        sbox_dout <= sbox_lu(sbox_sel, sbox_addr);
        cyc       <= cyc + 1;
    end

    always_comb l0_sbox_dout = sbox_lu(l0_sbox_sel, l0_sbox_addr);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
        l0_clr = 1'b0; l0_in_valid = 1'b0; l0_din = '0; l0_out_ready = 1'b0;
        #12;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (sbox_en !== 1'b0) begin n_err++; $display("FAIL rst_sbox_en: got %b want 0", sbox_en); end
        n_vec++; if (sbox_sel !== 3'd0) begin n_err++; $display("FAIL rst_sbox_sel: got %0d want 0", sbox_sel); end
        n_vec++; if (sbox_addr !== 6'd0) begin n_err++; $display("FAIL rst_sbox_addr: got %h want 00", sbox_addr); end
        n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_dout: got %h want 00000000", dout); end
        n_vec++; if (l0_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_l0_in_ready: got %b want 1", l0_in_ready); end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_lat1();
        int n;
        din = 48'h0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin tick(); n++; end
        n_vec++; if (n !== 10) begin n_err++; $display("FAIL lat1_out_time: got T+%0d want T+10", n); end
        n_vec++; if (dout !== 32'hEFA72C4D) begin n_err++; $display("FAIL lat1_zero_dout: got %h want EFA72C4D", dout); end
        tick();
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL lat1_after_hs: got ov/ir=%b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_ones_walk();
        int n;
        din = 48'hFFFF_FFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++; if ({sbox_en, sbox_sel} !== {1'b1, 3'(i)}) begin n_err++; $display("FAIL ones_sel_walk: got en/sel=%b/%0d want 1/%0d", sbox_en, sbox_sel, i); end
            n_vec++; if (sbox_addr !== 6'h3F) begin n_err++; $display("FAIL ones_addr: got %h want 3F", sbox_addr); end
            tick();
        end
        n_vec++; if ({sbox_en, sbox_sel} !== {1'b0, 3'd7}) begin n_err++; $display("FAIL ones_hold_sel: got en/sel=%b/%0d want 0/7", sbox_en, sbox_sel); end
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ones_timeout: got out_valid %b want 1", out_valid); end
        n_vec++; if (dout !== 32'hD9CE3DCB) begin n_err++; $display("FAIL ones_dout: got %h want D9CE3DCB", dout); end
        tick();
    endtask

    task automatic test_addr_walk();
        int n;
        din = 48'h0010_8310_5187; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (sbox_addr !== 6'(i)) begin n_err++; $display("FAIL addr_walk: got %0d want %0d", sbox_addr, i); end
            tick();
        end
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        n_vec++; if (dout !== 32'hE30844E8) begin n_err++; $display("FAIL addr_walk_dout: got %h want E30844E8", dout); end
        tick();
    endtask

    task automatic test_lat0();
        int n;
        l0_din = 48'h0; l0_in_valid = 1'b1; l0_out_ready = 1'b1;
        tick();
        l0_in_valid = 1'b0;
        n = 1;
        while (!l0_out_valid && n < 40) begin tick(); n++; end
        n_vec++; if (n !== 9) begin n_err++; $display("FAIL lat0_out_time: got T+%0d want T+9", n); end
        n_vec++; if (l0_dout !== 32'hEFA72C4D) begin n_err++; $display("FAIL lat0_dout: got %h want EFA72C4D", l0_dout); end
        tick();
        n_vec++; if (l0_out_valid !== 1'b0) begin n_err++; $display("FAIL lat0_after_hs: got %b want 0", l0_out_valid); end
    endtask

    task automatic test_stall();
        int n;
        din = 48'hFFFF_FFFF_FFFF; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        din = 48'h0010_8310_5187;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        for (int i = 0; i < 20; i++) begin
            n_vec++; if ({out_valid, in_ready, dout} !== {2'b10, 32'hD9CE3DCB}) begin n_err++; $display("FAIL stall_hold: got ov/ir/dout=%b/%b/%h want 1/0/D9CE3DCB", out_valid, in_ready, dout); end
            tick();
        end
        out_ready = 1'b1; din = 48'h0;
        tick();
        n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL stall_release: got ir/ov=%b want 10", {in_ready, out_valid}); end
        tick();
        in_valid = 1'b0;
        n_vec++; if ({sbox_en, sbox_sel, sbox_addr} !== {1'b1, 3'd0, 6'd0}) begin n_err++; $display("FAIL stall_next_accept: got en/sel/addr=%b/%0d/%h want 1/0/00", sbox_en, sbox_sel, sbox_addr); end
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        n_vec++; if (dout !== 32'hEFA72C4D) begin n_err++; $display("FAIL stall_next_dout: got %h want EFA72C4D", dout); end
        tick();
    endtask

    task automatic test_clr();
        int n;
        int seen;
        din = 48'h0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_vec++; if (sbox_sel !== 3'd4) begin n_err++; $display("FAIL clr_at_k4: got sel %0d want 4", sbox_sel); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++; if ({in_ready, sbox_en, dout} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL clr_idle: got ir/en/dout=%b/%b/%h want 1/0/00000000", in_ready, sbox_en, dout); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL clr_no_out: got %0d out_valid cycles want 0", seen); end
        din = 48'hFFFF_FFFF_FFFF; in_valid = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++; if ({in_ready, sbox_en} !== 2'b10) begin n_err++; $display("FAIL clr_blocks_accept: got ir/en=%b want 10", {in_ready, sbox_en}); end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        n_vec++; if (dout !== 32'hD9CE3DCB) begin n_err++; $display("FAIL clr_next_dout: got %h want D9CE3DCB", dout); end
        tick();
    endtask

    task automatic test_reset_mid_and_stream();
        int n;
        int seen;
        int prev;
        logic [63:0] r;
        logic [47:0] d;
        din = 48'h1234_5678_9ABC; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_vec++; if (sbox_sel !== 3'd2) begin n_err++; $display("FAIL rstmid_at_k2: got sel %0d want 2", sbox_sel); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({in_ready, out_valid, sbox_en, sbox_sel, sbox_addr, dout} !== {3'b100, 3'd0, 6'd0, 32'h0})
            begin n_err++; $display("FAIL rstmid_outputs: got ir/ov/en/sel/addr/dout=%b/%b/%b/%0d/%h/%h want 1/0/0/0/00/00000000", in_ready, out_valid, sbox_en, sbox_sel, sbox_addr, dout); end
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid || sbox_en) seen++;
            tick();
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", seen); end
        in_valid = 1'b1;
        prev = 0;
        for (int b = 0; b < 6; b++) begin
            r = {$urandom(), $urandom()};
            d = r[47:0];
            din = d;
            n = 0;
            while (!in_ready && n < 40) begin tick(); n++; end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_accept_timeout: got in_ready %b want 1", in_ready); end
            if (b > 0) begin
                n_vec++; if (cyc - prev !== 11) begin n_err++; $display("FAIL stream_period: got %0d want 11", cyc - prev); end
            end
            prev = cyc;
            tick();
            n = 0;
            while (!out_valid && n < 40) begin tick(); n++; end
            n_vec++; if (dout !== ref_f(d)) begin n_err++; $display("FAIL stream_dout: din %h got %h want %h", d, dout, ref_f(d)); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_lat1();
        test_ones_walk();
        test_addr_walk();
        test_lat0();
        test_stall();
        test_clr();
        test_reset_mid_and_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
